// File: rtl/imem_loader.sv
// imem_loader
// Fills the instruction memory from a byte stream before the core runs.
// Frame: 4-byte little-endian word count N, 4*N data bytes (little-endian
// words), then a 4-byte checksum equal to the sum of the N words mod 2**32.
// Each data word is written to BASE + 4*i with a one-cycle we pulse.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a load (honoured only in IDLE, DONE, ERR)
//   byte_valid in   byte_data is valid
//   byte_data  in   8-bit stream byte
//   byte_ready out  loader accepts a byte this cycle (HDR, DATA, CSUM)
//   we         out  instruction memory write enable, one cycle per word
//   waddr      out  word-aligned byte address of the write
//   wdata      out  word to write
//   cpu_hold   out  high while loading; keeps the core in reset
//   done       out  last load succeeded; held until next start
//   err        out  last load failed; held until next start
module imem_loader #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  // Largest legal word count is the full memory capacity.
  localparam logic [32:0]           CAP = 33'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   ONE = 1;

  state_t                state;
  logic [1:0]            bcnt;
  logic [23:0]           part;
  logic [31:0]           word;
  logic [ADDR_WIDTH:0]   nwords;
  logic [ADDR_WIDTH:0]   idx;
  logic [31:0]           sum;
  logic                  take;
  logic                  word_done;

  assign byte_ready = (state == HDR) || (state == DATA) || (state == CSUM);
  assign cpu_hold   = byte_ready;
  assign done       = (state == DONE);
  assign err        = (state == ERR);

  assign take      = byte_valid && byte_ready;
  assign word_done = take && (bcnt == 2'd3);

  // The 4th byte is used straight from the input so a completed word is
  // acted on in the same cycle it arrives.
  assign word = {byte_data, part};

  // Lower three bytes of the word being assembled. Pure data; a reset
  // clears bcnt, which is enough to discard a partial word.
  always_ff @(posedge clk) begin
    if (take) begin
      case (bcnt)
        2'd0:    part[7:0]   <= byte_data;
        2'd1:    part[15:8]  <= byte_data;
        2'd2:    part[23:16] <= byte_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      bcnt   <= 2'd0;
      nwords <= '0;
      idx    <= '0;
      sum    <= 32'd0;
      we     <= 1'b0;
      waddr  <= 32'd0;
      wdata  <= 32'd0;
    end else begin
      we <= 1'b0;
      if (take) bcnt <= bcnt + 2'd1;

      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state <= HDR;
            bcnt  <= 2'd0;
            idx   <= '0;
            sum   <= 32'd0;
          end
        end

        HDR: begin
          if (word_done) begin
            if ({1'b0, word} > CAP) begin
              state <= ERR;
            end else if (word == 32'd0) begin
              state <= CSUM;
            end else begin
              nwords <= word[ADDR_WIDTH:0];
              state  <= DATA;
            end
          end
        end

        DATA: begin
          if (word_done) begin
            we    <= 1'b1;
            waddr <= BASE + 32'({idx, 2'b00});
            wdata <= word;
            sum   <= sum + word;
            idx   <= idx + ONE;
            if (idx + ONE == nwords) state <= CSUM;
          end
        end

        CSUM: begin
          if (word_done) state <= (word == sum) ? DONE : ERR;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          CAPW = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  imem_loader #(.ADDR_WIDTH(10), .BASE(BASE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  int ncyc   = 0;

  always @(posedge clk) ncyc <= ncyc + 1;

  // Observed writes
  logic [31:0] got_a[$];
  logic [31:0] got_d[$];
  int          got_c[$];

  always @(negedge clk) begin
    if (we === 1'b1) begin
      got_a.push_back(waddr);
      got_d.push_back(wdata);
      got_c.push_back(ncyc);
    end
  end

  // Frame under test and reference expectations
  logic [7:0]  fq[$];
  int          xfer_c[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];
  int          exp_b[$];
  bit          exp_ok;
  int          nsend;
  bit          was_reset;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) fq.push_back(w[8*k +: 8]);
  endtask

  function automatic logic [31:0] le_word(input int at);
    return {fq[at+3], fq[at+2], fq[at+1], fq[at]};
  endfunction

  // Reference: parse the frame as the loader should, listing the writes,
  // the index of the byte that completes each word, the outcome, and how
  // many bytes the loader consumes before leaving the busy states.
  task automatic model();
    logic [31:0] n, w, s;
    exp_a.delete(); exp_d.delete(); exp_b.delete();
    n = le_word(0);
    if (n > 32'(CAPW)) begin
      exp_ok = 1'b0;
      nsend  = 4;
    end else begin
      s = 32'd0;
      for (int i = 0; i < int'(n); i++) begin
        w = le_word(4 + 4*i);
        exp_a.push_back(BASE + 32'(4*i));
        exp_d.push_back(w);
        exp_b.push_back(4 + 4*i + 3);
        s = s + w;
      end
      exp_ok = (le_word(4 + 4*int'(n)) == s);
      nsend  = 8 + 4*int'(n);
    end
  endtask

  // Called at a negedge; offers one byte and returns at the negedge after
  // the transfer edge.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    byte_valid = 1'b1;
    byte_data  = b;
    waited = 0;
    while (byte_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) begin
      chk("ready_timeout", 32'(byte_ready), 32'd1);
      byte_valid = 1'b0;
      return;
    end
    xfer_c.push_back(ncyc);
    @(posedge clk);
    #1 byte_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_frame(input string name, input int gap_pct, input int start_at,
                           input int rst_at);
    int gaps;
    got_a.delete(); got_d.delete(); got_c.delete(); xfer_c.delete();
    was_reset = 1'b0;
    model();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk({name, "_ready_after_start"}, 32'(byte_ready), 32'd1);
    chk({name, "_hold_after_start"},  32'(cpu_hold),   32'd1);
    chk({name, "_done_cleared"},      32'(done),       32'd0);
    chk({name, "_err_cleared"},       32'(err),        32'd0);
    for (int i = 0; i < nsend; i++) begin
      gaps = 0;
      while (gap_pct > 0 && gaps < 5 && $urandom_range(99) < 32'(gap_pct)) begin
        @(negedge clk);
        gaps++;
      end
      send_byte(fq[i]);
      if (i == start_at) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      if (i == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk({name, "_rst_ready"}, 32'(byte_ready), 32'd0);
        chk({name, "_rst_hold"},  32'(cpu_hold),   32'd0);
        chk({name, "_rst_we"},    32'(we),         32'd0);
        chk({name, "_rst_waddr"}, waddr,           32'd0);
        chk({name, "_rst_wdata"}, wdata,           32'd0);
        chk({name, "_rst_done"},  32'(done),       32'd0);
        chk({name, "_rst_err"},   32'(err),        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        was_reset = 1'b1;
        return;
      end
    end
    // Now at cycle t+1 after the final byte's edge.
    chk({name, "_done"},  32'(done),       32'(exp_ok));
    chk({name, "_err"},   32'(err),        32'(!exp_ok));
    chk({name, "_hold"},  32'(cpu_hold),   32'd0);
    chk({name, "_ready"}, 32'(byte_ready), 32'd0);
    chk({name, "_nwrites"}, 32'(got_a.size()), 32'(exp_a.size()));
    for (int k = 0; k < exp_a.size() && k < got_a.size(); k++) begin
      chk({name, "_waddr"}, got_a[k], exp_a[k]);
      chk({name, "_wdata"}, got_d[k], exp_d[k]);
      chk({name, "_wcycle"}, 32'(got_c[k]), 32'(xfer_c[exp_b[k]] + 1));
    end
    if (exp_a.size() > 0) begin
      chk({name, "_waddr_hold"}, waddr, exp_a[exp_a.size()-1]);
      chk({name, "_wdata_hold"}, wdata, exp_d[exp_d.size()-1]);
    end
  endtask

  task automatic normal_frame(input logic [31:0] csum);
    fq.delete();
    add_word(32'd2);
    add_word(32'h0050_0093);
    add_word(32'h00A0_0113);
    add_word(csum);
  endtask

  task automatic random_frame(input int n, input bit bad);
    logic [31:0] w, s;
    fq.delete();
    s = 32'd0;
    add_word(32'(n));
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      s = s + w;
      add_word(w);
    end
    add_word(bad ? s ^ (32'd1 << $urandom_range(31)) : s);
  endtask

  initial begin
    // Reset state
    #3;
    chk("reset_ready", 32'(byte_ready), 32'd0);
    chk("reset_we",    32'(we),         32'd0);
    chk("reset_waddr", waddr,           32'd0);
    chk("reset_wdata", wdata,           32'd0);
    chk("reset_hold",  32'(cpu_hold),   32'd0);
    chk("reset_done",  32'(done),       32'd0);
    chk("reset_err",   32'(err),        32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Start ignored? no: idle without start keeps everything low
    @(negedge clk);
    chk("idle_ready", 32'(byte_ready), 32'd0);

    normal_frame(32'h00F0_01A6);
    run_frame("normal", 0, -1, -1);

    normal_frame(32'h0000_0000);
    run_frame("badsum", 0, -1, -1);

    fq.delete();
    add_word(32'd1025);
    run_frame("oversize", 0, -1, -1);

    fq.delete();
    add_word(32'd0);
    add_word(32'd0);
    run_frame("empty", 0, -1, -1);

    normal_frame(32'h00F0_01A6);
    run_frame("gapped", 30, 6, -1);

    normal_frame(32'h00F0_01A6);
    run_frame("midreset", 0, -1, 5);
    run_frame("after_reset", 0, -1, -1);

    for (int r = 0; r < 6; r++) begin
      random_frame(int'($urandom_range(1, 8)), ($urandom_range(2) == 0));
      run_frame("random", 20, -1, -1);
    end

    random_frame(CAPW, 1'b0);
    run_frame("fullsize", 0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
